// File: rtl/grom_io_ctrl.sv
// grom_io_ctrl: registered display/LED ports, debounced switches, tick timer.
// Define GROM_IO_TIMER_EN to build the prescaled timer at port 0x02.
module grom_io_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PRESCALE        = 25000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] addr,
  input  logic [7:0]  data_in,
  input  logic        we,
  input  logic        ioreq,
  input  logic [3:0]  i_Switch,
  output logic [7:0]  data_out,
  output logic [7:0]  display_out,
  output logic [3:0]  led_out
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || PRESCALE < 1) begin : g_bad_cfg
    $error("grom_io_ctrl: need DEBOUNCE_CYCLES >= 2, PRESCALE >= 1");
  end

  logic [7:0] port;
  logic       wr;
  logic       rd;
  logic       unused_addr;

  assign port        = addr[7:0];
  assign wr          = ioreq & we;
  assign rd          = ioreq & ~we;
  assign unused_addr = ^addr[11:8];

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    state;
  logic [3:0]    flags;
  logic [3:0]    rise;
  logic [DW-1:0] cnt [4];
  logic          clr;

  always_comb begin
    rise = '0;
    for (int i = 0; i < 4; i++)
      rise[i] = sync2[i] & ~state[i] & (cnt[i] == DMAX);
  end

  assign clr = rd && (port == 8'h04);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      state <= '0;
      flags <= '0;
      for (int i = 0; i < 4; i++)
        cnt[i] <= '0;
    end else begin
      sync1 <= i_Switch;
      sync2 <= sync1;
      // set beats clear when a new edge lands on a flag read
      flags <= (flags & ~{4{clr}}) | rise;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == state[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DMAX) begin
          state[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [7:0] tmr_rd;

`ifdef GROM_IO_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic [7:0]    tmr;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
      tmr <= '0;
    end else if (wr && port == 8'h02) begin
      pre <= '0;
      tmr <= data_in;
    end else if (pre == PMAX) begin
      pre <= '0;
      tmr <= tmr + 8'h01;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign tmr_rd = tmr;
`else
  assign tmr_rd = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      display_out <= 8'h00;
      led_out     <= 4'h0;
      data_out    <= 8'h00;
    end else begin
      if (wr && port == 8'h00)
        display_out <= data_in;
      if (wr && port == 8'h01)
        led_out <= data_in[3:0];
      if (rd) begin
        case (port)
          8'h00:   data_out <= display_out;
          8'h01:   data_out <= {4'h0, led_out};
          8'h02:   data_out <= tmr_rd;
          8'h03:   data_out <= {4'h0, state};
          8'h04:   data_out <= {4'h0, flags};
          default: data_out <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_grom_io_ctrl.sv
// tb_grom_io_ctrl: directed stimulus, cycle-level model, per-cycle compare.
// Timer expectations follow GROM_IO_TIMER_EN.
module tb_grom_io_ctrl;

  localparam int DEB = 4;
  localparam int PRE = 3;
`ifdef GROM_IO_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] addr = '0;
  logic [7:0]  data_in = '0;
  logic        we = 1'b0;
  logic        ioreq = 1'b0;
  logic [3:0]  i_Switch = '0;
  logic [7:0]  data_out;
  logic [7:0]  display_out;
  logic [3:0]  led_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  grom_io_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .PRESCALE(PRE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .data_in(data_in),
    .we(we),
    .ioreq(ioreq),
    .i_Switch(i_Switch),
    .data_out(data_out),
    .display_out(display_out),
    .led_out(led_out)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  // Model: timer as arithmetic on time since last load, switches as
  // run lengths of disagreement between delayed raw input and state.
  bit         mv = 1'b0;
  int         cyc = 0;
  int         tw_cyc = 0;
  int         tw_val = 0;
  logic [7:0] m_disp = '0;
  logic [7:0] m_dout = '0;
  logic [3:0] m_led = '0;
  logic [3:0] m_state = '0;
  logic [3:0] m_flags = '0;
  logic [3:0] m_d1 = '0;
  logic [3:0] m_d2 = '0;
  int         m_run [4];

  function automatic logic [7:0] timer_now();
    int v;
    if (!TEN) return 8'h00;
    v = (tw_val + (cyc - 1 - tw_cyc) / PRE) % 256;
    return v[7:0];
  endfunction

  always @(posedge clk) begin
    logic [7:0] p;
    logic [7:0] tnow;
    logic [3:0] smp;
    p = addr[7:0];
    if (reset) begin
      mv      = 1'b1;
      m_disp  = '0;
      m_led   = '0;
      m_dout  = '0;
      m_state = '0;
      m_flags = '0;
      m_d1    = '0;
      m_d2    = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      tw_cyc  = cyc;
      tw_val  = 0;
    end else if (mv) begin
      tnow = timer_now();
      if (ioreq && !we) begin
        case (p)
          8'h00:   m_dout = m_disp;
          8'h01:   m_dout = {4'h0, m_led};
          8'h02:   m_dout = tnow;
          8'h03:   m_dout = {4'h0, m_state};
          8'h04:   m_dout = {4'h0, m_flags};
          default: m_dout = 8'h00;
        endcase
        if (p == 8'h04) m_flags = '0;
      end
      if (ioreq && we) begin
        if (p == 8'h00) m_disp = data_in;
        if (p == 8'h01) m_led = data_in[3:0];
        if (p == 8'h02 && TEN) begin
          tw_cyc = cyc;
          tw_val = int'(data_in);
        end
      end
      smp = m_d2;
      for (int i = 0; i < 4; i++) begin
        if (smp[i] != m_state[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_state[i] = smp[i];
            m_run[i]   = 0;
            if (smp[i]) m_flags[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = i_Switch;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (mv) begin
      chk("cyc_display", display_out, m_disp);
      chk("cyc_led", {4'h0, led_out}, {4'h0, m_led});
      chk("cyc_data", data_out, m_dout);
    end
  end

  task automatic step(input logic io, input logic w,
                      input logic [7:0] a, input logic [7:0] d);
    ioreq   = io;
    we      = w;
    addr    = {4'h5, a};
    data_in = d;
    @(negedge clk);
    ioreq = 1'b0;
    we    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                    input string nm);
    step(1'b1, 1'b0, a, 8'h00);
    chk(nm, data_out, exp);
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    chk("rst_display", display_out, 8'h00);
    chk("rst_led", {4'h0, led_out}, 8'h00);
    chk("rst_data", data_out, 8'h00);
    reset = 1'b0;

    step(1'b1, 1'b1, 8'h00, 8'hA5);
    step(1'b1, 1'b1, 8'h01, 8'hF6);
    chk("wr_display", display_out, 8'hA5);
    chk("wr_led", {4'h0, led_out}, 8'h06);
    rd(8'h01, 8'h06, "rd_led");
    rd(8'h00, 8'hA5, "rd_display");

    step(1'b0, 1'b1, 8'h00, 8'h3C);
    step(1'b1, 1'b1, 8'h07, 8'h11);
    chk("noio_display", display_out, 8'hA5);
    rd(8'h07, 8'h00, "rd_unmapped");

    i_Switch = 4'b0100;
    idle(3);
    i_Switch = 4'b0000;
    idle(8);
    rd(8'h03, 8'h00, "glitch_state");
    i_Switch = 4'b0100;
    idle(6);
    rd(8'h03, 8'h04, "sw_state");
    rd(8'h04, 8'h04, "flag_first");
    rd(8'h04, 8'h00, "flag_cleared");

    i_Switch = 4'b0101;
    idle(5);
    rd(8'h04, 8'h00, "flag_coincide");
    rd(8'h04, 8'h01, "flag_after");
    rd(8'h03, 8'h05, "sw_both");

    step(1'b1, 1'b1, 8'h02, 8'hFE);
    idle(9);
    rd(8'h02, TEN ? 8'h01 : 8'h00, "timer_wrap");
    idle(2);

    reset   = 1'b1;
    ioreq   = 1'b1;
    we      = 1'b1;
    addr    = 12'h000;
    data_in = 8'h77;
    @(negedge clk);
    reset = 1'b0;
    ioreq = 1'b0;
    we    = 1'b0;
    chk("rstmid_display", display_out, 8'h00);
    rd(8'h02, 8'h00, "rstmid_timer");
    idle(1);
    step(1'b1, 1'b1, 8'h02, 8'h10);
    idle(2);
    rd(8'h02, TEN ? 8'h10 : 8'h00, "timer_wr_vs_tick");
    rd(8'h00, 8'h00, "rstmid_rd_display");

    step(1'b1, 1'b1, 8'h02, 8'h55);
    idle(10);
    rd(8'h02, TEN ? 8'h58 : 8'h00, "timer_55");
    idle(12);
    rd(8'h03, 8'h05, "sw_after_rst");
    rd(8'h04, 8'h05, "flags_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
